// File: rtl/color_scan_ctrl.sv
// color_scan_ctrl
//   Sequences a TCS3200-style colour sensor through RED, GREEN, BLUE and
//   CLEAR filters. Each filter step has three parts:
//     - a settle window, during which sensor edges are discarded;
//     - a fixed gate window, during which rising edges of sensor_out are
//       counted;
//     - a store cycle.
//   The four counts are published together as one frame with a one-cycle
//   sample_valid strobe.
//
//   Optional feature: define GREEN_DETECT_EN to build the green-percentage
//   classifier driving is_green. Without it, is_green is tied to 0.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin one frame (only looked at in IDLE)
//   continuous          rescan automatically after each frame
//   sensor_out          asynchronous sensor frequency output
//   s2, s3              filter select: RED=00 GREEN=11 BLUE=01 CLEAR=10
//   busy                high in every state except IDLE
//   sample_valid        one-cycle strobe, new frame on *_cnt
//   red/green/blue/clear_cnt   frame results, held between frames
//   cnt_ovf             some filter counter saturated in this frame
//   is_green            green classification (GREEN_DETECT_EN only)
module color_scan_ctrl #(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 16,
  parameter int PCT_LO        = 57,
  parameter int PCT_HI        = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             sensor_out,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic             sample_valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic             cnt_ovf,
  output logic             is_green
);

  localparam int TMAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, DONE} state_t;

  state_t                       state;
  logic [1:0]                   f;        // 0=RED 1=GREEN 2=BLUE 3=CLEAR
  logic [TMR_W-1:0]             tmr;
  logic [CNT_W-1:0]             cnt;
  logic [3:0][CNT_W-1:0]        shadow;
  logic [3:0]                   ovf;
  logic [2:0]                   sync;     // [1] = sync2, [2] = edge-detect delay
  logic                         edge_det;

  assign edge_det = sync[1] & ~sync[2];

  // Filter index to {s2,s3} pin code.
  function automatic logic [1:0] sel_code(input logic [1:0] idx);
    case (idx)
      2'd0:    sel_code = 2'b00;
      2'd1:    sel_code = 2'b11;
      2'd2:    sel_code = 2'b01;
      default: sel_code = 2'b10;
    endcase
  endfunction

`ifdef GREEN_DETECT_EN
  localparam int PW = CNT_W + 7;
  logic [PW-1:0] g100, c_lo, c_hi;
  logic          green_hit;
  // Percentage window checked by cross-multiplying, so no divider is needed.
  always_comb begin
    g100      = PW'(shadow[1]) * PW'(100);
    c_lo      = PW'(shadow[3]) * PW'(PCT_LO);
    c_hi      = PW'(shadow[3]) * PW'(PCT_HI);
    green_hit = (g100 >= c_lo) && (g100 <= c_hi) && (shadow[3] != '0) && !(|ovf);
  end
`else
  assign is_green = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      f            <= '0;
      tmr          <= '0;
      cnt          <= '0;
      shadow       <= '0;
      ovf          <= '0;
      sync         <= '0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      red_cnt      <= '0;
      green_cnt    <= '0;
      blue_cnt     <= '0;
      clear_cnt    <= '0;
      cnt_ovf      <= 1'b0;
`ifdef GREEN_DETECT_EN
      is_green     <= 1'b0;
`endif
    end else begin
      sync         <= {sync[1:0], sensor_out};
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETTLE;
            f        <= 2'd0;
            {s2, s3} <= sel_code(2'd0);
            tmr      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end
        SETTLE: begin
          if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
            tmr   <= '0;
            state <= GATE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        GATE: begin
          // Saturating counter: stops at all-ones instead of wrapping.
          if (edge_det && (cnt != '1)) cnt <= cnt + 1'b1;
          if (tmr == TMR_W'(GATE_CYCLES - 1)) begin
            tmr   <= '0;
            state <= STORE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STORE: begin
          shadow[f] <= cnt;
          ovf[f]    <= &cnt;
          cnt       <= '0;
          if (f == 2'd3) begin
            state <= DONE;
          end else begin
            f        <= f + 2'd1;
            {s2, s3} <= sel_code(f + 2'd1);
            state    <= SETTLE;
          end
        end
        DONE: begin
          red_cnt      <= shadow[0];
          green_cnt    <= shadow[1];
          blue_cnt     <= shadow[2];
          clear_cnt    <= shadow[3];
          cnt_ovf      <= |ovf;
          sample_valid <= 1'b1;
`ifdef GREEN_DETECT_EN
          is_green     <= green_hit;
`endif
          f        <= 2'd0;
          {s2, s3} <= sel_code(2'd0);
          if (continuous) begin
            state <= SETTLE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_scan_ctrl.sv
// Directed bench for color_scan_ctrl. GATE=100, SETTLE=10 for the main
// instance (CNT_W=8) and a second CNT_W=5 instance fed a period-2 sensor.
// The sensor model picks its period from the current s2/s3 code. Rising
// edges land every p cycles, so a 100-cycle gate sees exactly 100/p of them
// when p divides 100.
module tb_color_scan_ctrl;
  localparam int G  = 100;
  localparam int S  = 10;
  localparam int FS = S + G + 1;         // cycles per filter step
  localparam int FR = 4 * FS + 1;        // start-to-valid latency

  logic clk = 0, rst_n = 0, start = 0, continuous = 0, sensor = 0;
  logic sensor5 = 0, cont5 = 0;
  logic s2, s3, busy, sample_valid, cnt_ovf, is_green;
  logic [7:0] red_cnt, green_cnt, blue_cnt, clear_cnt;
  logic s2_5, s3_5, busy5, valid5, ovf5, green5;
  logic [4:0] r5, g5, b5, c5;

  int total = 0, bad = 0;
  int per_r = 10, per_g = 10, per_b = 10, per_c = 10;
  int ph = 0, sp;

  always #5 clk = ~clk;

  color_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .sensor_out(sensor), .s2(s2), .s3(s3), .busy(busy),
    .sample_valid(sample_valid), .red_cnt(red_cnt), .green_cnt(green_cnt),
    .blue_cnt(blue_cnt), .clear_cnt(clear_cnt), .cnt_ovf(cnt_ovf),
    .is_green(is_green));

  color_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(cont5),
    .sensor_out(sensor5), .s2(s2_5), .s3(s3_5), .busy(busy5),
    .sample_valid(valid5), .red_cnt(r5), .green_cnt(g5),
    .blue_cnt(b5), .clear_cnt(c5), .cnt_ovf(ovf5), .is_green(green5));

  // Sensor model: period chosen by the active filter; 0 = no output.
  always @(negedge clk) begin
    ph = ph + 1;
    case ({s2, s3})
      2'b00:   sp = per_r;
      2'b11:   sp = per_g;
      2'b01:   sp = per_b;
      default: sp = per_c;
    endcase
    sensor  = (sp == 0) ? 1'b0 : ((ph % sp) < (sp / 2));
    sensor5 = ~sensor5;
  end

  typedef struct {
    int pr, pg, pb, pc;
    int er, eg, eb, ec;
    int eo;
  } vec_t;
  vec_t vt[4];
  int sel_exp[4];

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, act, exp);
    end
  endtask

  // Pulse start, then wait (bounded) for sample_valid. Returns the cycle
  // count since the edge that accepted start.
  task automatic run_frame(output int cyc, input bit chk_sel);
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    cyc = 0;
    while (cyc < FR + 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (chk_sel && (cyc % FS == 50) && (cyc < 4 * FS))
        chk("sel", int'({s2, s3}), sel_exp[cyc / FS]);
      if (sample_valid) break;
    end
  endtask

  task automatic set_per(input int r, input int g, input int b, input int c);
    per_r = r; per_g = g; per_b = b; per_c = c;
  endtask

  initial begin
    int cyc, nv;
    vt[0] = '{10, 10, 10, 10, 10, 10, 10, 10, 0};
    vt[1] = '{5, 10, 20, 4, 20, 10, 5, 25, 0};
    vt[2] = '{4, 4, 4, 4, 25, 25, 25, 25, 0};
    vt[3] = '{20, 2, 50, 100, 5, 50, 2, 1, 0};
    sel_exp = '{0, 3, 1, 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_sel", int'({s2, s3}), 0);
    chk("rst_cnts", red_cnt | green_cnt | blue_cnt | clear_cnt, 0);
    chk("rst_ovf", cnt_ovf, 0);
    chk("rst_green", is_green, 0);
    rst_n = 1;

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      set_per(vt[i].pr, vt[i].pg, vt[i].pb, vt[i].pc);
      run_frame(cyc, i == 0);
      chk("latency", cyc, FR);
      chk("red", red_cnt, vt[i].er);
      chk("green", green_cnt, vt[i].eg);
      chk("blue", blue_cnt, vt[i].eb);
      chk("clear", clear_cnt, vt[i].ec);
      chk("ovf", cnt_ovf, vt[i].eo);
`ifndef GREEN_DETECT_EN
      chk("is_green_off", is_green, 0);
`endif
      if (i == 0) begin
        chk("sat_valid", valid5, 1);
        chk("sat_red", r5, 31);
        chk("sat_green", g5, 31);
        chk("sat_blue", b5, 31);
        chk("sat_clear", c5, 31);
        chk("sat_ovf", ovf5, 1);
      end
      @(posedge clk);
      #1;
      chk("busy_after", busy, 0);
      chk("valid_1cyc", sample_valid, 0);
      chk("hold_red", red_cnt, vt[i].er);
    end

    // Continuous mode: frame 2 spaced one frame later; stray start and
    // dropping continuous mid-frame must not disturb it.
    set_per(10, 10, 10, 10);
    continuous = 1;
    run_frame(cyc, 0);
    chk("cont_f1", cyc, FR);
    cyc = 0;
    while (cyc < FR + 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 20) start = 1;
      if (cyc == 21) start = 0;
      if (cyc == 200) continuous = 0;
      if (sample_valid) break;
    end
    chk("cont_gap", cyc, FR - 1 + 1);
    chk("cont_red", red_cnt, 10);
    nv = 0;
    repeat (500) begin
      @(posedge clk);
      #1;
      if (sample_valid) nv++;
    end
    chk("cont_stop_valid", nv, 0);
    chk("cont_stop_busy", busy, 0);

    // Reset in the middle of the BLUE gate
    set_per(5, 10, 20, 4);
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (2 * FS + 50) @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    chk("mid_busy", busy, 0);
    chk("mid_sel", int'({s2, s3}), 0);
    chk("mid_cnts", red_cnt | green_cnt | blue_cnt | clear_cnt, 0);
    chk("mid_valid", sample_valid, 0);
    nv = 0;
    repeat (500) begin
      @(posedge clk);
      #1;
      if (sample_valid || busy) nv++;
    end
    chk("mid_quiet", nv, 0);
    run_frame(cyc, 1);
    chk("post_latency", cyc, FR);
    chk("post_red", red_cnt, 20);
    chk("post_clear", clear_cnt, 25);

`ifdef GREEN_DETECT_EN
    // green/clear near 7/10 (in window), about 9/10 (above), clear=0
    set_per(10, 14, 10, 10);
    run_frame(cyc, 0);
    chk("green_in", is_green, 1);
    set_per(10, 11, 10, 10);
    run_frame(cyc, 0);
    chk("green_hi", is_green, 0);
    set_per(10, 10, 10, 0);
    run_frame(cyc, 0);
    chk("green_c0", is_green, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
